// File: rtl/dist_seg_display.sv
// -----------------------------------------------------------------------------
// dist_seg_display
//
// Takes the ultrasonic ranger's 8-bit distance count (1 count = 2.7 cm) and
// shows it on the Basys2 4-digit 7-segment display as centimetres with one
// decimal place ("ddd.d").
//
// Processing chain:
//  - The count is resynchronised into clk.
//  - It is multiplied by 27 to get millimetres.
//  - A sequential double-dabble engine converts the millimetre value to BCD.
//  - The display shows "----" when the count is at or above MAX_COUNT.
//
// Parameters
//   SCAN_BITS  width of the free-running digit-scan counter
//   MAX_COUNT  counts >= MAX_COUNT are over-range
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   dis_value  distance count from the ranger (asynchronous, may glitch)
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   an         digit anodes, active-low, an[0] = rightmost digit
//   mm_value   current distance in millimetres (count * 27)
//   over       current sample is over-range
//   busy       BCD conversion pending or in progress
// -----------------------------------------------------------------------------
module dist_seg_display #(
   parameter int SCAN_BITS = 16,
   parameter int MAX_COUNT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  dis_value,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [12:0] mm_value,
   output logic        over,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Ten bits so that a MAX_COUNT of 256 (never over-range) is representable.
   localparam logic [9:0] MAX_CNT = 10'(MAX_COUNT);
   localparam logic [3:0] LAST_IT = 4'd12;

   logic [7:0]           s1_q, s1_d, s2_q, s2_d, cur_q, cur_d;
   logic [12:0]          mm_q, mm_d;
   logic                 over_q, over_d;
   logic                 pend_q, pend_d;
   state_t               state_q, state_d;
   logic [28:0]          sh_q, sh_d, sh_adj;
   logic [3:0]           it_q, it_d;
   logic [15:0]          dig_q, dig_d;
   logic [SCAN_BITS-1:0] scan_q, scan_d;
   logic                 started_q, started_d;
   logic [1:0]           d_q, d_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [3:0]           an_q, an_d;

   logic                 accept;
   logic                 wrap;
   logic                 blank;
   logic [12:0]          cur_ext;
   logic [3:0]           nib;

   function automatic logic [6:0] seg_enc(input logic [3:0] v);
      case (v)
         4'd0:    seg_enc = 7'h40;
         4'd1:    seg_enc = 7'h79;
         4'd2:    seg_enc = 7'h24;
         4'd3:    seg_enc = 7'h30;
         4'd4:    seg_enc = 7'h19;
         4'd5:    seg_enc = 7'h12;
         4'd6:    seg_enc = 7'h02;
         4'd7:    seg_enc = 7'h78;
         4'd8:    seg_enc = 7'h00;
         4'd9:    seg_enc = 7'h10;
         default: seg_enc = 7'h7F;
      endcase
   endfunction

   // busy also covers the cycle between a new mm_value and the start of its
   // conversion, so the capture stage cannot slip another value in there.
   assign busy = pend_q || (state_q == ST_SHIFT);

   // ---------------- capture and multiply ----------------
   always_comb begin
      s1_d    = dis_value;
      s2_d    = s1_q;
      // Only a value seen identically on two consecutive clocks is trusted.
      accept  = (s1_q == s2_q) && (s2_q != cur_q) && !busy;
      cur_d   = accept ? s2_q : cur_q;
      cur_ext = {5'd0, cur_q};
      mm_d    = (cur_ext << 4) + (cur_ext << 3) + (cur_ext << 1) + cur_ext;
      over_d  = ({2'b00, cur_q} >= MAX_CNT);
   end

   // ---------------- double-dabble adjust ----------------
   // BCD nibbles live in sh[28:13]; the binary value shifts out of sh[12:0].
   for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib_in;
      assign nib_in                   = sh_q[13 + 4*gi +: 4];
      assign sh_adj[13 + 4*gi +: 4]   = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;
   end
   assign sh_adj[12:0] = sh_q[12:0];

   // ---------------- conversion FSM ----------------
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      it_d    = it_q;
      dig_d   = dig_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               state_d = ST_SHIFT;
               sh_d    = {16'd0, mm_q};
               it_d    = 4'd0;
               pend_d  = 1'b0;
            end
         end
         ST_SHIFT: begin
            sh_d = {sh_adj[27:0], 1'b0};
            it_d = it_q + 4'd1;
            if (it_q == LAST_IT) begin
               state_d = ST_DONE;
               // Digits are committed on the final shift edge so they land
               // 14 clocks after mm_value changes.
               dig_d   = sh_adj[27:12];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A fresh mm_value always leaves a pending request behind, even if it
      // arrives on the same edge a conversion starts.
      if (mm_d != mm_q) begin
         pend_d = 1'b1;
      end
   end

   // ---------------- digit scan ----------------
   always_comb begin
      wrap      = &scan_q;
      scan_d    = scan_q + SCAN_BITS'(1);
      started_d = started_q | wrap;
      // The first wrap only enables the anodes; the index starts at digit 0.
      d_d       = (wrap && started_q) ? (d_q + 2'd1) : d_q;
      an_d      = started_d ? ~(4'b0001 << d_d) : 4'hF;
      nib       = dig_q[{d_d, 2'b00} +: 4];
      case (d_d)
         2'd3:    blank = (dig_q[15:12] == 4'd0);
         2'd2:    blank = (dig_q[15:8] == 8'd0);
         default: blank = 1'b0;
      endcase
      if (!started_d) begin
         seg_d = 7'h7F;
      end else if (over_q) begin
         seg_d = 7'b0111111;
      end else if (blank) begin
         seg_d = 7'h7F;
      end else begin
         seg_d = seg_enc(nib);
      end
      dp_d = !(started_d && !over_q && (d_d == 2'd1));
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= 8'd0;
         s2_q      <= 8'd0;
         cur_q     <= 8'd0;
         mm_q      <= 13'd0;
         over_q    <= 1'b0;
         pend_q    <= 1'b0;
         state_q   <= ST_IDLE;
         sh_q      <= 29'd0;
         it_q      <= 4'd0;
         dig_q     <= 16'd0;
         scan_q    <= '0;
         started_q <= 1'b0;
         d_q       <= 2'd0;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         an_q      <= 4'hF;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cur_q     <= cur_d;
         mm_q      <= mm_d;
         over_q    <= over_d;
         pend_q    <= pend_d;
         state_q   <= state_d;
         sh_q      <= sh_d;
         it_q      <= it_d;
         dig_q     <= dig_d;
         scan_q    <= scan_d;
         started_q <= started_d;
         d_q       <= d_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;
   assign mm_value = mm_q;
   assign over     = over_q;

endmodule
